// File: rtl/exec_stage.sv
// Execute stage of the 64-bit pipeline: combinational ALU, NZCV flags and the EX/MEM register.
// Define MUL_EN to build the iterative shift-add multiplier (alu_op 8); otherwise op 8 is reserved.
module exec_stage #(
  parameter int MUL_BITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [3:0]  alu_op,
  input  logic [63:0] a_in,
  input  logic [63:0] b_in,
  input  logic [63:0] store_data_in,
  input  logic [4:0]  write_reg_in,
  input  logic        mem_write_in,
  input  logic        mem_read_in,
  input  logic        mem_to_reg_in,
  input  logic        reg_write_in,
  input  logic        set_flags_in,
  input  logic        stall_in,
  input  logic        flush_in,
  output logic [63:0] ex_result,
  output logic [63:0] store_data_out,
  output logic [4:0]  write_reg_out,
  output logic        mem_write_out,
  output logic        mem_read_out,
  output logic        mem_to_reg_out,
  output logic        reg_write_out,
  output logic [3:0]  flags_out,
  output logic [63:0] result_forwarding,
  output logic [4:0]  write_reg_forwarding,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_AND   = 4'd2;
  localparam logic [3:0] OP_ORR   = 4'd3;
  localparam logic [3:0] OP_EOR   = 4'd4;
  localparam logic [3:0] OP_LSL   = 4'd5;
  localparam logic [3:0] OP_LSR   = 4'd6;
  localparam logic [3:0] OP_PASSB = 4'd7;

  logic [63:0] w_b_op;
  logic        w_cin;
  logic [64:0] w_sum;
  logic [63:0] w_alu_result;
  logic        w_is_addsub;
  logic [3:0]  w_flags_next;

  // SUB is A + ~B + 1, so the adder carry is the no-borrow flag directly.
  assign w_is_addsub = (alu_op == OP_ADD) || (alu_op == OP_SUB);
  assign w_b_op      = (alu_op == OP_SUB) ? ~b_in : b_in;
  assign w_cin       = (alu_op == OP_SUB);
  assign w_sum       = {1'b0, a_in} + {1'b0, w_b_op} + {64'd0, w_cin};

  always_comb begin
    w_alu_result = 64'd0;
    case (alu_op)
      OP_ADD, OP_SUB: w_alu_result = w_sum[63:0];
      OP_AND:         w_alu_result = a_in & b_in;
      OP_ORR:         w_alu_result = a_in | b_in;
      OP_EOR:         w_alu_result = a_in ^ b_in;
      OP_LSL:         w_alu_result = a_in << b_in[5:0];
      OP_LSR:         w_alu_result = a_in >> b_in[5:0];
      OP_PASSB:       w_alu_result = b_in;
      default:        w_alu_result = 64'd0;
    endcase
  end

  assign w_flags_next = {w_sum[63],
                         (w_sum[63:0] == 64'd0),
                         w_sum[64],
                         (a_in[63] == w_b_op[63]) && (w_sum[63] != a_in[63])};

  logic        w_take;
  logic [63:0] w_value;
  logic        w_flags_ok;
  logic        w_flags_upd;

`ifdef MUL_EN
  localparam logic [3:0] OP_MUL       = 4'd8;
  localparam logic [6:0] MUL_CNT_INIT = 7'(64 / MUL_BITS_PER_CYCLE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic        r_busy;
  logic [6:0]  r_cnt;
  logic [63:0] r_acc;
  logic [63:0] r_mcand;
  logic [63:0] r_mplier;
  logic [63:0] w_acc_next;
  logic        w_mul_issue;

  assign w_mul_issue = valid_in && (alu_op == OP_MUL);

  always_comb begin
    w_acc_next = r_acc;
    for (int k = 0; k < MUL_BITS_PER_CYCLE; k++) begin
      if (r_mplier[k]) w_acc_next = w_acc_next + (r_mcand << k);
    end
  end

  // Handshake: busy is the only backpressure. While busy=1 upstream holds the ID/EX inputs
  // stable; DONE re-reads them for the controls. stall_in freezes, flush_in aborts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= S_IDLE;
      r_busy   <= 1'b0;
      r_cnt    <= 7'd0;
      r_acc    <= 64'd0;
      r_mcand  <= 64'd0;
      r_mplier <= 64'd0;
    end else if (flush_in) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else if (!stall_in) begin
      case (r_state)
        S_IDLE: begin
          if (w_mul_issue) begin
            r_mcand  <= a_in;
            r_mplier <= b_in;
            r_acc    <= 64'd0;
            r_cnt    <= MUL_CNT_INIT;
            r_state  <= S_RUN;
            r_busy   <= 1'b1;
          end
        end
        S_RUN: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << MUL_BITS_PER_CYCLE;
          r_mplier <= r_mplier >> MUL_BITS_PER_CYCLE;
          r_cnt    <= r_cnt - 7'd1;
          if (r_cnt == 7'd1) r_state <= S_DONE;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_take     = valid_in;
    w_value    = w_alu_result;
    w_flags_ok = 1'b1;
    case (r_state)
      S_IDLE: if (w_mul_issue) w_take = 1'b0;
      S_RUN: begin
        w_take     = 1'b0;
        w_flags_ok = 1'b0;
      end
      S_DONE: begin
        w_value    = r_acc;
        w_flags_ok = 1'b0;
      end
      default: w_take = 1'b0;
    endcase
  end

  assign busy      = r_busy;
  assign dbg_state = r_state;
`else
  assign w_take     = valid_in;
  assign w_value    = w_alu_result;
  assign w_flags_ok = 1'b1;
  assign busy       = 1'b0;
  assign dbg_state  = 2'b00;
`endif

  assign w_flags_upd = w_take && w_flags_ok && w_is_addsub && set_flags_in;

  logic [63:0] r_result;
  logic [63:0] r_store_data;
  logic [4:0]  r_write_reg;
  logic [3:0]  r_ctl;
  logic [3:0]  r_flags;

  // Bubbles clear the data fields too, so an idle EX/MEM reads as all zeros.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_result     <= 64'd0;
      r_store_data <= 64'd0;
      r_write_reg  <= 5'd0;
      r_ctl        <= 4'd0;
      r_flags      <= 4'd0;
    end else if (flush_in) begin
      r_result     <= 64'd0;
      r_store_data <= 64'd0;
      r_write_reg  <= 5'd0;
      r_ctl        <= 4'd0;
    end else if (!stall_in) begin
      if (w_take) begin
        r_result     <= w_value;
        r_store_data <= store_data_in;
        r_write_reg  <= write_reg_in;
        r_ctl        <= {mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in};
      end else begin
        r_result     <= 64'd0;
        r_store_data <= 64'd0;
        r_write_reg  <= 5'd0;
        r_ctl        <= 4'd0;
      end
      if (w_flags_upd) r_flags <= w_flags_next;
    end
  end

  assign ex_result            = r_result;
  assign store_data_out       = r_store_data;
  assign write_reg_out        = r_write_reg;
  assign mem_write_out        = r_ctl[3];
  assign mem_read_out         = r_ctl[2];
  assign mem_to_reg_out       = r_ctl[1];
  assign reg_write_out        = r_ctl[0];
  assign flags_out            = r_flags;
  assign result_forwarding    = w_value;
  assign write_reg_forwarding = write_reg_in;

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: ALU ops, flags, stall/flush, async reset and,
// when MUL_EN is defined, the iterative multiplier.
module tb_exec_stage;

  localparam int MBPC    = 1;
  localparam int MUL_LAT = 64 / MBPC + 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [3:0]  alu_op = 4'd0;
  logic [63:0] a_in = 64'd0;
  logic [63:0] b_in = 64'd0;
  logic [63:0] store_data_in = 64'd0;
  logic [4:0]  write_reg_in = 5'd0;
  logic        mem_write_in = 1'b0;
  logic        mem_read_in = 1'b0;
  logic        mem_to_reg_in = 1'b0;
  logic        reg_write_in = 1'b0;
  logic        set_flags_in = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush_in = 1'b0;
  logic [63:0] ex_result;
  logic [63:0] store_data_out;
  logic [4:0]  write_reg_out;
  logic        mem_write_out;
  logic        mem_read_out;
  logic        mem_to_reg_out;
  logic        reg_write_out;
  logic [3:0]  flags_out;
  logic [63:0] result_forwarding;
  logic [4:0]  write_reg_forwarding;
  logic        busy;
  logic [1:0]  dbg_state;

  always #5 clk = ~clk;

  exec_stage #(.MUL_BITS_PER_CYCLE(MBPC)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .alu_op(alu_op),
    .a_in(a_in), .b_in(b_in), .store_data_in(store_data_in), .write_reg_in(write_reg_in),
    .mem_write_in(mem_write_in), .mem_read_in(mem_read_in), .mem_to_reg_in(mem_to_reg_in),
    .reg_write_in(reg_write_in), .set_flags_in(set_flags_in), .stall_in(stall_in),
    .flush_in(flush_in), .ex_result(ex_result), .store_data_out(store_data_out),
    .write_reg_out(write_reg_out), .mem_write_out(mem_write_out), .mem_read_out(mem_read_out),
    .mem_to_reg_out(mem_to_reg_out), .reg_write_out(reg_write_out), .flags_out(flags_out),
    .result_forwarding(result_forwarding), .write_reg_forwarding(write_reg_forwarding),
    .busy(busy), .dbg_state(dbg_state)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [136:0] exp_q[$];
  logic [136:0] exp_v;
  logic [136:0] last_exp = '0;
  logic [3:0]   exp_flags = 4'd0;

  // {result, store data, write reg, {mem_write, mem_read, mem_to_reg, reg_write}}
  function automatic logic [136:0] pack_exp(input logic [63:0] res, input logic [63:0] sd,
                                            input logic [4:0] wr, input logic [3:0] ctl);
    return {res, sd, wr, ctl};
  endfunction

  function automatic logic [136:0] dut_exmem();
    return {ex_result, store_data_out, write_reg_out,
            mem_write_out, mem_read_out, mem_to_reg_out, reg_write_out};
  endfunction

  function automatic logic [63:0] model_alu(input logic [3:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << b[5:0];
      4'd6: return a >> b[5:0];
      4'd7: return b;
`ifdef MUL_EN
      4'd8: return a * b;
`endif
      default: return 64'd0;
    endcase
  endfunction

  task automatic drive(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] sd, input logic [4:0] wr, input logic [3:0] ctl,
                       input logic sf, input logic v);
    valid_in = v; alu_op = op; a_in = a; b_in = b; store_data_in = sd; write_reg_in = wr;
    {mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in} = ctl;
    set_flags_in = sf;
  endtask

  task automatic drive_idle();
    drive(4'd0, 64'd0, 64'd0, 64'd0, 5'd0, 4'd0, 1'b0, 1'b0);
    stall_in = 1'b0;
    flush_in = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive_idle();
    #2;
    n_tests++;
    if (dut_exmem() !== '0) begin
      n_fail++; $display("FAIL reset_exmem got %h exp 0", dut_exmem());
    end
    n_tests++;
    if (flags_out !== 4'd0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL reset_state flags %b busy %b state %0d exp 0/0/0", flags_out, busy, dbg_state);
    end
    step(); step();
    reset_n = 1'b1;
    step();
    n_tests++;
    if (dut_exmem() !== '0) begin
      n_fail++; $display("FAIL idle_bubble got %h exp 0", dut_exmem());
    end
  endtask

  task automatic test_add();
    drive(4'd0, 64'd5, 64'd7, 64'd0, 5'd3, 4'b0001, 1'b1, 1'b1);
    exp_q.push_back(pack_exp(64'd12, 64'd0, 5'd3, 4'b0001));
    #1;
    n_tests++;
    if (result_forwarding !== 64'd12 || write_reg_forwarding !== 5'd3) begin
      n_fail++; $display("FAIL add_forward got %h/%0d exp 12/3", result_forwarding, write_reg_forwarding);
    end
    step();
    exp_v = exp_q.pop_front();
    last_exp = exp_v;
    n_tests++;
    if (dut_exmem() !== exp_v) begin
      n_fail++; $display("FAIL add_exmem got %h exp %h", dut_exmem(), exp_v);
    end
    exp_flags = 4'b0000;
    n_tests++;
    if (flags_out !== exp_flags) begin
      n_fail++; $display("FAIL add_flags got %b exp %b", flags_out, exp_flags);
    end
  endtask

  task automatic test_sub_flags();
    logic [3:0]  t_op[8]  = '{4'd1, 4'd1, 4'd2, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
    logic [63:0] t_a[8]   = '{64'd3, 64'h8000_0000_0000_0000, 64'hFF, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
                              64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] t_b[8]   = '{64'd3, 64'd1, 64'h0F, 64'd1, 64'd1, 64'd1, 64'd2, 64'd1};
    logic        t_sf[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        t_v[8]   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [3:0]  t_nzcv[8] = '{4'b0110, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b1001, 4'b1000, 4'b0110};
    for (int i = 0; i < 8; i++) begin
      drive(t_op[i], t_a[i], t_b[i], 64'd0, 5'(i + 4), 4'b0001, t_sf[i], t_v[i]);
      if (t_v[i]) exp_q.push_back(pack_exp(model_alu(t_op[i], t_a[i], t_b[i]), 64'd0, 5'(i + 4), 4'b0001));
      else        exp_q.push_back('0);
      step();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (dut_exmem() !== exp_v) begin
        n_fail++; $display("FAIL flags_exmem[%0d] got %h exp %h", i, dut_exmem(), exp_v);
      end
      exp_flags = t_nzcv[i];
      n_tests++;
      if (flags_out !== exp_flags) begin
        n_fail++; $display("FAIL flags_nzcv[%0d] got %b exp %b", i, flags_out, exp_flags);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  ops[12] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd9, 4'd15, 4'd0, 4'd1, 4'd12, 4'd5};
    logic [3:0]  op;
    logic [63:0] a, b, sd, exp_res;
    logic [4:0]  wr;
    logic [3:0]  ctl;
    for (int i = 0; i < 24; i++) begin
      op  = ops[$urandom_range(0, 11)];
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sd  = {$urandom, $urandom};
      wr  = 5'($urandom_range(0, 31));
      ctl = 4'($urandom_range(1, 15));
      exp_res = model_alu(op, a, b);
      drive(op, a, b, sd, wr, ctl, 1'b0, 1'b1);
      exp_q.push_back(pack_exp(exp_res, sd, wr, ctl));
      #1;
      n_tests++;
      if (result_forwarding !== exp_res) begin
        n_fail++; $display("FAIL b2b_forward[%0d] op %0d got %h exp %h", i, op, result_forwarding, exp_res);
      end
      step();
      exp_v = exp_q.pop_front();
      n_tests++;
      if (dut_exmem() !== exp_v) begin
        n_fail++; $display("FAIL b2b_exmem[%0d] op %0d got %h exp %h", i, op, dut_exmem(), exp_v);
      end
    end
    n_tests++;
    if (flags_out !== exp_flags) begin
      n_fail++; $display("FAIL b2b_flags_hold got %b exp %b", flags_out, exp_flags);
    end
  endtask

  task automatic test_stall_stur();
    drive(4'd3, 64'hF0, 64'h0F, 64'h1234, 5'd7, 4'b0001, 1'b0, 1'b1);
    exp_q.push_back(pack_exp(64'hFF, 64'h1234, 5'd7, 4'b0001));
    step();
    exp_v = exp_q.pop_front();
    last_exp = exp_v;
    n_tests++;
    if (dut_exmem() !== exp_v) begin
      n_fail++; $display("FAIL stur_prior got %h exp %h", dut_exmem(), exp_v);
    end
    drive(4'd0, 64'h100, 64'd8, 64'hDEAD, 5'd0, 4'b1000, 1'b0, 1'b1);
    stall_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_tests++;
      if (dut_exmem() !== last_exp) begin
        n_fail++; $display("FAIL stur_stall_hold[%0d] got %h exp %h", i, dut_exmem(), last_exp);
      end
    end
    stall_in = 1'b0;
    exp_q.push_back(pack_exp(64'h108, 64'hDEAD, 5'd0, 4'b1000));
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (dut_exmem() !== exp_v) begin
      n_fail++; $display("FAIL stur_release got %h exp %h", dut_exmem(), exp_v);
    end
    // flag-setting SUB held by stall: flags must not move until the stall lifts
    drive(4'd1, 64'd5, 64'd5, 64'd0, 5'd2, 4'b0001, 1'b1, 1'b1);
    stall_in = 1'b1;
    step();
    n_tests++;
    if (flags_out !== exp_flags) begin
      n_fail++; $display("FAIL stall_flags_hold got %b exp %b", flags_out, exp_flags);
    end
    stall_in = 1'b0;
    step();
    exp_flags = 4'b0110;
    n_tests++;
    if (flags_out !== exp_flags) begin
      n_fail++; $display("FAIL stall_flags_release got %b exp %b", flags_out, exp_flags);
    end
    drive_idle();
  endtask

  task automatic test_mul();
`ifdef MUL_EN
    int bad;
    logic [63:0] a, b;
    drive(4'd8, 64'd6, 64'd7, 64'h55, 5'd9, 4'b0001, 1'b1, 1'b1);
    exp_q.push_back(pack_exp(64'd42, 64'h55, 5'd9, 4'b0001));
    #1;
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL mul_busy_pre got %b exp 0", busy);
    end
    bad = 0;
    for (int e = 1; e < MUL_LAT; e++) begin
      step();
      if (busy !== 1'b1 || dut_exmem() !== '0) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mul_run_bubbles got %0d bad cycles exp 0", bad);
    end
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (dut_exmem() !== exp_v) begin
      n_fail++; $display("FAIL mul_result got %h exp %h", dut_exmem(), exp_v);
    end
    n_tests++;
    if (busy !== 1'b0 || flags_out !== exp_flags) begin
      n_fail++; $display("FAIL mul_done_state busy %b flags %b exp 0/%b", busy, flags_out, exp_flags);
    end
    // second MUL issues straight from the IDLE cycle, with a 3-edge stall mid-run
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    drive(4'd8, a, b, 64'h77, 5'd17, 4'b0011, 1'b0, 1'b1);
    exp_q.push_back(pack_exp(a * b, 64'h77, 5'd17, 4'b0011));
    bad = 0;
    for (int e = 1; e < MUL_LAT + 3; e++) begin
      stall_in = (e >= 11 && e <= 13);
      step();
      if (busy !== 1'b1 || dut_exmem() !== '0) bad++;
    end
    stall_in = 1'b0;
    n_tests++;
    if (bad != 0) begin
      n_fail++; $display("FAIL mul_stall_bubbles got %0d bad cycles exp 0", bad);
    end
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (dut_exmem() !== exp_v) begin
      n_fail++; $display("FAIL mul_b2b_result got %h exp %h", dut_exmem(), exp_v);
    end
    drive_idle();
`else
    drive(4'd8, 64'd6, 64'd7, 64'h55, 5'd9, 4'b0001, 1'b1, 1'b1);
    exp_q.push_back(pack_exp(64'd0, 64'h55, 5'd9, 4'b0001));
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (dut_exmem() !== exp_v || busy !== 1'b0) begin
      n_fail++; $display("FAIL mul_reserved got %h busy %b exp %h busy 0", dut_exmem(), busy, exp_v);
    end
    drive_idle();
`endif
  endtask

  task automatic test_flush();
    drive(4'd1, 64'd9, 64'd2, 64'd0, 5'd6, 4'b0001, 1'b1, 1'b1);
    flush_in = 1'b1;
    step();
    flush_in = 1'b0;
    n_tests++;
    if (dut_exmem() !== '0 || flags_out !== exp_flags) begin
      n_fail++; $display("FAIL flush_bubble got %h flags %b exp 0 flags %b", dut_exmem(), flags_out, exp_flags);
    end
`ifdef MUL_EN
    drive(4'd8, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd0, 5'd5, 4'b0001, 1'b0, 1'b1);
    for (int e = 1; e <= 5; e++) step();
    n_tests++;
    if (busy !== 1'b1 || dbg_state !== 2'd1) begin
      n_fail++; $display("FAIL flush_mul_running busy %b state %0d exp 1/1", busy, dbg_state);
    end
    flush_in = 1'b1;
    step();
    drive_idle();
    n_tests++;
    if (busy !== 1'b0 || dbg_state !== 2'd0 || dut_exmem() !== '0) begin
      n_fail++; $display("FAIL flush_mul_abort busy %b state %0d exmem %h exp 0/0/0", busy, dbg_state, dut_exmem());
    end
    step();
    n_tests++;
    if (busy !== 1'b0 || dut_exmem() !== '0) begin
      n_fail++; $display("FAIL flush_mul_stays_idle busy %b exmem %h exp 0/0", busy, dut_exmem());
    end
`endif
    drive(4'd0, 64'd1, 64'd1, 64'd0, 5'd10, 4'b0001, 1'b0, 1'b1);
    exp_q.push_back(pack_exp(64'd2, 64'd0, 5'd10, 4'b0001));
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (dut_exmem() !== exp_v) begin
      n_fail++; $display("FAIL flush_then_add got %h exp %h", dut_exmem(), exp_v);
    end
    drive_idle();
  endtask

  task automatic test_async_reset();
    drive(4'd3, 64'hA0, 64'h0B, 64'h99, 5'd12, 4'b0101, 1'b0, 1'b1);
    step();
`ifdef MUL_EN
    drive(4'd8, 64'd123, 64'd456, 64'd0, 5'd1, 4'b0001, 1'b0, 1'b1);
    for (int e = 0; e < 10; e++) step();
`endif
    #3;
    reset_n = 1'b0;
    #1;
    n_tests++;
    if (dut_exmem() !== '0 || flags_out !== 4'd0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
      n_fail++; $display("FAIL async_reset exmem %h flags %b busy %b state %0d exp all 0",
                         dut_exmem(), flags_out, busy, dbg_state);
    end
    exp_q.delete();
    exp_flags = 4'd0;
    drive_idle();
    @(posedge clk);
    #4;
    reset_n = 1'b1;
    step();
    drive(4'd5, 64'd1, 64'd63, 64'd0, 5'd1, 4'b0001, 1'b0, 1'b1);
    exp_q.push_back(pack_exp(64'h8000_0000_0000_0000, 64'd0, 5'd1, 4'b0001));
    step();
    exp_v = exp_q.pop_front();
    n_tests++;
    if (dut_exmem() !== exp_v || flags_out !== exp_flags) begin
      n_fail++; $display("FAIL post_reset_lsl got %h flags %b exp %h flags %b", dut_exmem(), flags_out, exp_v, exp_flags);
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_flags();
    test_back_to_back();
    test_stall_stur();
    test_mul();
    test_flush();
    test_async_reset();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain got %0d entries exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/exec_stage.md
Name: exec_stage

Overview:
- Execute stage of the 5-stage 64-bit pipeline, directly upstream of the memory stage.
- Performs the ALU operation and an iterative multi-cycle multiply, and maintains the NZCV flag register.
- Captures the result, store data, destination register and memory/writeback controls into the EX/MEM pipeline register that feeds the memory stage.
- Provides combinational forwarding taps of the current-cycle result and destination register.

Parameters:
MUL_BITS_PER_CYCLE, 1, multiplier bits retired per cycle; legal values 1, 2, 4, 8; MUL latency = 64/MUL_BITS_PER_CYCLE cycles

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous reset, active-low
valid_in  input  1  ID/EX holds a real instruction
alu_op  input  4  0 ADD, 1 SUB, 2 AND, 3 ORR, 4 EOR, 5 LSL, 6 LSR, 7 PASSB, 8 MUL, others reserved
a_in  input  64  operand A
b_in  input  64  operand B (immediate already muxed)
store_data_in  input  64  STUR data
write_reg_in  input  5  destination register
mem_write_in, mem_read_in, mem_to_reg_in, reg_write_in, set_flags_in  input  1 each  decoded controls
stall_in  input  1  hold the entire stage
flush_in  input  1  squash the instruction in EX
ex_result  output  64  EX/MEM result (memory address or ALU value)
store_data_out  output  64  EX/MEM store data
write_reg_out  output  5  EX/MEM destination register
mem_write_out, mem_read_out, mem_to_reg_out, reg_write_out  output  1 each  EX/MEM controls
flags_out  output  4  registered {N,Z,C,V}
result_forwarding  output  64  combinational current-cycle ALU result
write_reg_forwarding  output  5  equals write_reg_in
busy  output  1  multiply in progress; upstream holds ID/EX

Behaviour:
- Reset (reset_n=0, asynchronous): all EX/MEM outputs 0, flags_out 0, FSM in IDLE, busy 0.
- ALU is combinational:
  - ADD/SUB are 64-bit with carry out; SUB is A + ~B + 1.
  - LSL/LSR shift by b_in[5:0].
  - PASSB outputs b_in.
  - Reserved ops produce 0.
- Single-cycle ops: 1-cycle latency. With valid_in=1 and no stall/flush, the EX/MEM register loads at the next edge.
- valid_in=0 loads a bubble: all four controls 0, data fields don't-care but driven to 0.
- Flags:
  - Updated at the same edge as the EX/MEM load, only for valid ADD/SUB with set_flags_in=1.
  - N = result[63]; Z = (result==0); C = carry out; V = signed overflow.
  - SUB carry follows the no-borrow convention: C=1 when A >= B unsigned.
  - All other cases hold the flags.
- MUL FSM, states IDLE, RUN, DONE:
  - IDLE -> RUN when valid_in and alu_op=MUL. This edge latches the operands, clears the accumulator, loads the counter with 64/MUL_BITS_PER_CYCLE, and loads a bubble into EX/MEM.
  - RUN: shift-add retires MUL_BITS_PER_CYCLE bits per edge and decrements the counter. EX/MEM loads a bubble each edge.
  - RUN -> DONE when the counter reaches 0.
  - DONE: EX/MEM loads the low 64 bits of the product plus the controls; flags are not affected. Then DONE -> IDLE.
  - busy = 1 in RUN and DONE, 0 in IDLE.
  - Upstream holds the ID/EX inputs stable while busy=1; the stage re-reads the controls in DONE.
  - Total latency from MUL issue to EX/MEM valid: 64/MUL_BITS_PER_CYCLE + 2 edges.
- Priority at an edge: reset > flush > stall > normal.
  - flush_in=1: EX/MEM loads a bubble, flags hold, FSM returns to IDLE (aborts any multiply), busy drops after the edge.
  - stall_in=1 without flush: EX/MEM, flags, FSM state and counter all hold.
- Reset asserted mid-multiply: immediate return to IDLE, partial product discarded.
- Back-to-back MULs: the second MUL issues in the cycle after DONE (IDLE). There is no overlap.

Optional Feature:
MUL_EN
- Defined: MUL FSM, accumulator and busy logic are present as above.
- Undefined: alu_op=8 is treated as reserved (1-cycle, result 0), busy is tied to 0, and no multiplier logic is synthesized.

Test Plan:
- ADD a=5, b=7, set_flags_in=1, reg_write_in=1, write_reg_in=3 -> next edge: ex_result=12, write_reg_out=3, reg_write_out=1, flags=0000.
- SUB a=3, b=3 with set_flags_in -> flags NZCV=0110. Then SUB a=0x8000000000000000, b=1 -> result 0x7FFFFFFFFFFFFFFF, NZCV=0011.
- MUL a=6, b=7, MUL_BITS_PER_CYCLE=1 -> busy high for 65 cycles, bubbles in EX/MEM meanwhile, ex_result=42 at edge 66, busy low afterwards.
- MUL a=0xFFFFFFFFFFFFFFFF, b=2, MUL_BITS_PER_CYCLE=4, flush_in pulsed in the 5th RUN cycle -> EX/MEM stays a bubble, busy drops, FSM IDLE. A following ADD 1+1 gives 2 normally.
- STUR path: mem_write_in=1, a=0x100, b=8, store_data_in=0xDEAD, stall_in=1 for 2 cycles then 0 -> EX/MEM holds its prior contents during the stall, then ex_result=0x108, store_data_out=0xDEAD, mem_write_out=1.
- reset_n driven low asynchronously mid-cycle during RUN -> all outputs 0 immediately, busy 0. After release, LSL a=1, b=63 -> ex_result=0x8000000000000000.
